// File: rtl/shift_register_univ.sv
// Universal shift register: parallel load, logical/rotate/arithmetic shifts,
// serial in/out at both ends, and an autonomous burst engine that repeats a
// latched shift mode n times with busy/done status.
module shift_register_univ #(
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CW-1:0]    n,
  output logic [WIDTH-1:0] q,
  output logic             so_l,
  output logic             so_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state, state_nxt;
  op_e              mode_r, mode_r_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;

  // Result of one operation on the current register value; load, hold and
  // the reserved code never shift.
  function automatic logic [WIDTH-1:0] apply_op(
    input op_e              op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      OP_LOAD: res = din;
      OP_SHL:  res = {cur[WIDTH-2:0], sl};
      OP_SHR:  res = {sr, cur[WIDTH-1:1]};
      OP_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ROR:  res = {cur[0], cur[WIDTH-1:1]};
      OP_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: res = cur;
    endcase
    return res;
  endfunction

  // Only the shift family may be run as a burst; load/hold ignore start.
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m >= OP_SHL) && (m <= OP_ASR);
  endfunction

  // Next-state and next-register computation, priority clr > freeze > RUN > start > op.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    q_nxt      = q;
    state_nxt  = state;
    cnt_nxt    = cnt;
    mode_r_nxt = mode_r;
    done_nxt   = done;
    if (clr) begin
      q_nxt     = '0;
      state_nxt = IDLE;
      cnt_nxt   = '0;
      done_nxt  = 1'b0;
    end else if (en) begin
      done_nxt = 1'b0;
      if (state == RUN) begin
        if (cnt != '0) begin
          q_nxt   = apply_op(mode_r, q, d, sin_l, sin_r);
          cnt_nxt = cnt - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end else if (start && is_burst_mode(mode)) begin
        cnt_nxt    = n;
        mode_r_nxt = op_e'(mode);
        state_nxt  = RUN;
      end else begin
        q_nxt = apply_op(op_e'(mode), q, d, sin_l, sin_r);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    if (!reset) begin
      q      <= '0;
      state  <= IDLE;
      cnt    <= '0;
      mode_r <= OP_HOLD;
      done   <= 1'b0;
    end else begin
      q      <= q_nxt;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_r <= mode_r_nxt;
      done   <= done_nxt;
    end
  end

  assign so_l = q[WIDTH-1];
  assign so_r = q[0];
  assign busy = (state == RUN);

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed bench for shift_register_univ (WIDTH=8): modes, bursts, enable
// freeze, clear abort, start corner cases and asynchronous reset.
module tb_shift_register_univ;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             clr;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic             start;
  logic [CW-1:0]    n;
  logic [WIDTH-1:0] q;
  logic             so_l;
  logic             so_r;
  logic             busy;
  logic             done;

  int total  = 0;
  int passed = 0;

  shift_register_univ #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (clr),
    .mode  (mode),
    .d     (d),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .start (start),
    .n     (n),
    .q     (q),
    .so_l  (so_l),
    .so_r  (so_r),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports tag/observed/expected on failure.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // q plus status in one go.
  task automatic check_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic check_so(input string tag, input logic el, input logic er);
    check({tag, ".so_l"}, 32'(so_l), 32'(el));
    check({tag, ".so_r"}, 32'(so_r), 32'(er));
  endtask

  task automatic do_load(input logic [7:0] v);
    mode = 3'b001; d = v; start = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; clr = 1'b0; mode = 3'b000; d = '0;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; n = '0;
    step(); step();
    check_st("reset", 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    check_st("post_reset_hold", 8'h00, 1'b0, 1'b0);

    // ---- single-step modes ----
    do_load(8'hA5);                    check("load_a5", 32'(q), 32'h A5); check_so("load_a5", 1, 1);
    mode = 3'b010; sin_l = 1'b1; step(); check("shl", 32'(q), 32'h4B);    check_so("shl", 0, 1);
    mode = 3'b011; sin_r = 1'b0; step(); check("shr", 32'(q), 32'h25);    check_so("shr", 0, 1);
    do_load(8'h81);
    mode = 3'b100; step();              check("rol", 32'(q), 32'h03);     check_so("rol", 0, 1);
    do_load(8'h81);
    mode = 3'b101; step();              check("ror", 32'(q), 32'hC0);     check_so("ror", 1, 0);
    do_load(8'h90);
    mode = 3'b110; step();              check("asr", 32'(q), 32'hC8);     check_so("asr", 1, 0);
    mode = 3'b111; step();              check("rsvd", 32'(q), 32'hC8);
    mode = 3'b000; step();              check("hold", 32'(q), 32'hC8);

    // ---- burst ROL n=3, then done stretched by en=0 ----
    do_load(8'h01);
    mode = 3'b100; start = 1'b1; n = 4'd3; step();
    check_st("b_accept", 8'h01, 1, 0);
    start = 1'b0; mode = 3'b000;
    step(); check_st("b_s1", 8'h02, 1, 0);
    step(); check_st("b_s2", 8'h04, 1, 0);
    step(); check_st("b_s3", 8'h08, 1, 0);
    step(); check_st("b_done", 8'h08, 0, 1);
    en = 1'b0;
    step(); check_st("b_done_stretch", 8'h08, 0, 1);
    en = 1'b1;
    step(); check_st("b_after", 8'h08, 0, 0);

    // ---- enable freeze mid-burst ----
    do_load(8'h01);
    mode = 3'b010; sin_l = 1'b0; start = 1'b1; n = 4'd4; step();
    check_st("f_accept", 8'h01, 1, 0);
    start = 1'b0; mode = 3'b000;
    step(); check_st("f_s1", 8'h02, 1, 0);
    step(); check_st("f_s2", 8'h04, 1, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_st("f_frozen", 8'h04, 1, 0);
    end
    en = 1'b1;
    step(); check_st("f_s3", 8'h08, 1, 0);
    step(); check_st("f_s4", 8'h10, 1, 0);
    step(); check_st("f_done", 8'h10, 0, 1);
    step(); check_st("f_after", 8'h10, 0, 0);

    // ---- clear aborts a burst ----
    do_load(8'hF0);
    mode = 3'b101; start = 1'b1; n = 4'd6; step();
    check_st("c_accept", 8'hF0, 1, 0);
    start = 1'b0; mode = 3'b000;
    step(); check_st("c_s1", 8'h78, 1, 0);
    step(); check_st("c_s2", 8'h3C, 1, 0);
    clr = 1'b1;
    step(); check_st("c_clr", 8'h00, 0, 0);
    clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); check_st("c_no_done", 8'h00, 0, 0);
    end
    do_load(8'h81);
    mode = 3'b100; start = 1'b1; n = 4'd1; step();
    check_st("c_restart", 8'h81, 1, 0);
    start = 1'b0; mode = 3'b000;
    step(); check_st("c_r_s1", 8'h03, 1, 0);
    step(); check_st("c_r_done", 8'h03, 0, 1);

    // ---- start corner cases ----
    mode = 3'b001; d = 8'h3C; start = 1'b1; n = 4'd3; step();
    check_st("e_start_load", 8'h3C, 0, 0);
    mode = 3'b110; start = 1'b1; n = 4'd0; step();
    check_st("e_n0_accept", 8'h3C, 1, 0);
    start = 1'b0; mode = 3'b000;
    step(); check_st("e_n0_done", 8'h3C, 0, 1);
    mode = 3'b100; start = 1'b1; n = 4'd1; step();
    check_st("e_b2b_accept", 8'h3C, 1, 0);
    start = 1'b0; mode = 3'b000;
    step(); check_st("e_b2b_s1", 8'h78, 1, 0);
    step(); check_st("e_b2b_done", 8'h78, 0, 1);
    check_so("e_b2b", 0, 0);

    // ---- asynchronous reset mid-burst ----
    do_load(8'hA5);
    mode = 3'b100; start = 1'b1; n = 4'd5; step();
    start = 1'b0; mode = 3'b000;
    step(); check_st("r_s1", 8'h4B, 1, 0);
    #2 reset = 1'b0;
    #1 check_st("r_async", 8'h00, 0, 0);
    reset = 1'b1;
    step(); check_st("r_after", 8'h00, 0, 0);
    step(); check_st("r_after2", 8'h00, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_register_univ.md
# shift_register_univ

Parametrised universal shift register: the next generation of the team's fixed-width parallel-load register. It adds WIDTH generalisation, enable, synchronous clear, shift/rotate/arithmetic modes and serial ports. An autonomous burst engine applies a latched shift mode N times, with busy/done status. It is intended for serialisers, bit-manipulation datapaths and scan-style register chains.

## Interface
- WIDTH, 8, register width in bits (≥2); derived CW = $clog2(WIDTH)+1 is the burst count width
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- en  input  1  clock enable; 0 freezes q, state and count
- clr  input  1  synchronous clear, honoured regardless of en
- mode  input  3  operation select (see Operation)
- d  input  WIDTH  parallel load data
- sin_l  input  1  serial in, enters q[0] on SHL
- sin_r  input  1  serial in, enters q[WIDTH-1] on SHR
- start  input  1  request burst of n shifts using current mode
- n  input  CW  burst shift count
- q  output  WIDTH  register contents
- so_l  output  1  q[WIDTH-1] (combinational)
- so_r  output  1  q[0] (combinational)
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at burst completion

## Operation
- Modes: 000 hold; 001 load q←d; 010 SHL q←{q[W-2:0],sin_l}; 011 SHR q←{sin_r,q[W-1:1]}; 100 ROL q←{q[W-2:0],q[W-1]}; 101 ROR q←{q[0],q[W-1:1]}; 110 ASR q←{q[W-1],q[W-1:1]}; 111 reserved = hold.
- States: IDLE, RUN. Registers: q, state, cnt (CW bits), mode_r (3 bits), done.
- Priority per edge: reset > clr > en=0 (freeze) > RUN > start > mode op.
- IDLE, en=1, start=0: apply mode to q once.
- IDLE, en=1, start=1, mode ∈ {010..110}: cnt←n, mode_r←mode, state←RUN; q unchanged on this edge.
- IDLE, start=1, mode ∈ {000,001,111}: start ignored; mode op applied normally (load/hold).
- RUN, en=1: if cnt≠0, apply mode_r to q (sin_l/sin_r sampled live) and cnt←cnt−1. If cnt=0, state←IDLE, done←1, q unchanged.
- In RUN, mode, d and start are ignored.
- clr (en ignored): q←0, state←IDLE, cnt←0, done←0. An aborted burst produces no done.
- en=0: all registers hold, including done. A pending done pulse stretches until the next enabled edge.
- reset=0: immediately q=0, state=IDLE, cnt=0, mode_r=000, busy=0, done=0.

## Timing
- Single-op latency: one edge; q valid after the edge that samples mode.
- Burst accepted at edge k with n: shifts at edges k+1..k+n; edge k+n+1 returns to IDLE.
- busy=1 for cycles following edges k..k+n (n+1 cycles).
- done=1 for exactly the one cycle following edge k+n+1, with busy=0 in that cycle.
- n=0: no shift, busy for 1 cycle, then done.
- Back-to-back: start may be asserted in the done cycle and is accepted (state is IDLE).
- Reset deassertion is asynchronous-in; first active edge after reset=1 operates normally.
- so_l/so_r follow q combinationally with no extra latency.

## Test plan
- Reset: load 0xA5, start ROL n=5, pull reset=0 mid-burst → q=0x00, busy=0, done=0 immediately, before the next clk edge.
- Modes (WIDTH=8): load 0xA5; SHL sin_l=1 → 0x4B; SHR sin_r=0 → 0x25; load 0x81, ROL → 0x03; load 0x81, ROR → 0xC0; load 0x90, ASR → 0xC8; mode 111 → unchanged. Check so_l/so_r each step.
- Burst: load 0x01, start ROL n=3 → q 0x02, 0x04, 0x08 on successive edges; busy 4 cycles; done one cycle; q stays 0x08.
- Enable freeze: burst SHL n=4 from 0x01, sin_l=0, en=0 for 3 cycles after the second shift → q holds 0x04, busy stays 1. Resume → final 0x10 and a single done pulse.
- Clear abort: burst ROR n=6 from 0xF0, assert clr after 2 shifts → q=0x00, busy=0, no done pulse. A following start is accepted normally.
- Edge cases: start with mode=001 and d=0x3C → plain load 0x3C, busy stays 0. start ASR n=0 → q unchanged, busy 1 cycle, then done. start in the done cycle → new burst accepted.
